cdr_lock_ctrl: RTL and testbench
================================

// Module: cdr_lock_ctrl
// PURPOSE
//  Sequencer and lock detector for the CDR loop (BBPD -> DLF -> PI). Watches BBPD Up/Dn over fixed
//  windows. Steps the DLF through hold, high-gain acquire and low-gain track. Declares and drops lock.
//  Sits beside the loop in the PI clock domain. Drives DLF gain/hold and the RX-level lock flag.
// PARAMETERS
//  WIN_LOG2     8   window length = 2**WIN_LOG2 clk cycles
//  ACQ_WINDOWS  4   minimum windows spent in ACQ before TRACK may be entered
//  LOCK_WINDOWS 4   consecutive good windows in TRACK needed to declare lock
//  LOCK_THR     16  |up-dn| <= LOCK_THR marks a good window
//  UNLOCK_THR   64  |up-dn| >  UNLOCK_THR marks a bad window; LOCK_THR < UNLOCK_THR (elaboration check)
// PORTS
//  clk          in   1            recovered PI clock; the same clock used by BBPD and DLF
//  rst_n        in   1            reset, synchronous, active-low
//  en           in   1            loop enable; 0 forces IDLE
//  Up           in   1            BBPD early indication
//  Dn           in   1            BBPD late indication
//  gain_sel     out  2            DLF gain: 0 hold, 1 track (low), 2 acquire (high)
//  dlf_hold     out  1            freeze DLF integrator/code
//  cdr_locked   out  1            lock flag
//  lock_lost    out  1            1-cycle pulse on a LOCKED -> ACQ exit
//  state_o      out  2            current state (cdr_state_e)
//  imbalance_o  out  WIN_LOG2+2   signed up_cnt-dn_cnt of last completed window
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE, all counters 0, gain_sel 0, dlf_hold 1, cdr_locked 0,
//    lock_lost 0, imbalance_o 0. Reset has priority over en.
//  - All outputs are registered. A decision made on a window's last cycle is visible on the next cycle.
//  - Sampling: each cycle in ACQ/TRACK/LOCKED, Up&!Dn -> up_cnt++, Dn&!Up -> dn_cnt++.
//    Up&Dn or neither: no count.
//  - Counter widths: up_cnt and dn_cnt are WIN_LOG2+1 bits. They never saturate (max 2**WIN_LOG2).
//  - Window: wcnt runs 0..2**WIN_LOG2-1 from entry into ACQ and wraps.
//  - Window end: the last cycle (wcnt = all ones). That cycle's sample is included.
//    net = up_cnt - dn_cnt (signed, WIN_LOG2+2 bits). mag = |net|. net is loaded into imbalance_o.
//    up_cnt and dn_cnt restart at 0.
//  - Window class:
//      inconclusive: up_cnt+dn_cnt == 0
//      good:         otherwise, mag <= LOCK_THR
//      bad:          mag > UNLOCK_THR
//      neutral:      otherwise
//  - States (cdr_state_e):
//    IDLE:   gain 0, dlf_hold 1. If en=1 -> ACQ next cycle, with wcnt, acq_cnt and good_cnt cleared.
//    ACQ:    gain 2, dlf_hold 0.
//            acq_cnt counts every window end, saturating at ACQ_WINDOWS.
//            Go to TRACK at a window end when acq_cnt (including this window) >= ACQ_WINDOWS and the window is good.
//    TRACK:  gain 1. A good window increments good_cnt. A neutral window clears it. An inconclusive window holds it.
//            A bad window -> ACQ (acq_cnt and good_cnt cleared, no lock_lost).
//            good_cnt reaching LOCK_WINDOWS -> LOCKED.
//    LOCKED: gain 1, cdr_locked 1. A bad window -> ACQ, lock_lost=1 for one cycle, cdr_locked 0 on that same cycle.
//            Good, neutral and inconclusive windows: stay.
//  - en=0 in any state: IDLE on the next cycle. Counters and imbalance_o are cleared. An in-progress window is discarded.
//  - Re-enable always restarts a full ACQ_WINDOWS acquisition.
// STRUCTURE
//  - cdr_ctrl_pkg:
//    typedef enum logic[1:0] cdr_state_e {IDLE=0, ACQ=1, TRACK=2, LOCKED=3}
//    typedef enum logic[1:0] cdr_gain_e {GAIN_HOLD=0, GAIN_TRACK=1, GAIN_ACQ=2}
//  - Sub-module cdr_win_accum: Up/Dn accumulation, wcnt, win_end strobe, signed net/mag, class flags.
//    Its inputs are clear and run.
//  - Top: FSM, acq_cnt/good_cnt, output registers. Include an immediate assertion on the LOCK_THR < UNLOCK_THR check.
// TESTING (bench parameters: WIN_LOG2=4, ACQ_WINDOWS=4, LOCK_WINDOWS=4, LOCK_THR=2, UNLOCK_THR=8)
//  1. rst_n=0 for 3 cycles with en=1, Up=1
//     -> state_o 0, gain_sel 0, dlf_hold 1, cdr_locked 0, imbalance_o 0 throughout.
//  2. en=1, Up=1 every cycle
//     -> ACQ forever, gain_sel 2, imbalance_o=+16 after each window, never TRACK.
//  3. en=1, Up/Dn alternating
//     -> TRACK visible at cycle 65 after entering ACQ.
//     -> LOCKED and cdr_locked=1 at cycle 129.
//     -> imbalance_o=0 at every window.
//  4. From LOCKED, one window of Up only (net=+16)
//     -> lock_lost high exactly 1 cycle, cdr_locked 0 and gain_sel 2 on that cycle, then re-lock per scenario 3.
//  5. In TRACK with good_cnt=2:
//     a) window with Up=Dn=1 every cycle -> inconclusive, good_cnt stays 2.
//     b) then window net=+5 -> neutral, good_cnt 0.
//     c) then 4 good windows -> LOCKED.
//  6. en dropped mid-window in TRACK
//     -> IDLE next cycle, imbalance_o 0, dlf_hold 1.
//     -> re-enable needs a full 4 ACQ windows again before TRACK.

Source files
------------

// File: rtl/cdr_ctrl_pkg.sv
// cdr_ctrl_pkg: shared state and gain encodings for the CDR lock controller
package cdr_ctrl_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, TRACK = 2'd2, LOCKED = 2'd3} cdr_state_e;
   typedef enum logic [1:0] {GAIN_HOLD = 2'd0, GAIN_TRACK = 2'd1, GAIN_ACQ = 2'd2} cdr_gain_e;
endpackage

// File: rtl/cdr_lock_ctrl_win_accum.sv
// cdr_win_accum: per-window BBPD up/dn tally, window-end strobe, signed net and window class
module cdr_win_accum #(
   parameter int WIN_LOG2   = 8,
   parameter int LOCK_THR   = 16,
   parameter int UNLOCK_THR = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       run,
   input  logic                       up,
   input  logic                       dn,
   output logic                       win_end,
   output logic signed [WIN_LOG2+1:0] net,
   output logic                       good,
   output logic                       bad,
   output logic                       inconc
);
   logic [WIN_LOG2-1:0] wcnt;
   logic [WIN_LOG2:0]   up_cnt, dn_cnt, up_f, dn_f;
   logic [WIN_LOG2+1:0] mag;
   always_comb begin
      up_f    = up_cnt + (WIN_LOG2+1)'(up & ~dn);
      dn_f    = dn_cnt + (WIN_LOG2+1)'(dn & ~up);
      net     = $signed({1'b0, up_f}) - $signed({1'b0, dn_f});
      mag     = net[WIN_LOG2+1] ? -net : net;
      win_end = run && (&wcnt);
      inconc  = (up_f == '0) && (dn_f == '0);
      good    = !inconc && (mag <= (WIN_LOG2+2)'(LOCK_THR));
      bad     = mag > (WIN_LOG2+2)'(UNLOCK_THR);
   end
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wcnt   <= '0;
         up_cnt <= '0;
         dn_cnt <= '0;
      end else if (run) begin
         wcnt   <= wcnt + WIN_LOG2'(1);
         up_cnt <= win_end ? '0 : up_f;
         dn_cnt <= win_end ? '0 : dn_f;
      end
   end
endmodule

// File: rtl/cdr_lock_ctrl.sv
// cdr_lock_ctrl: CDR loop sequencer (hold/acquire/track) and window-based lock detector
module cdr_lock_ctrl
   import cdr_ctrl_pkg::*;
#(
   parameter int WIN_LOG2     = 8,
   parameter int ACQ_WINDOWS  = 4,
   parameter int LOCK_WINDOWS = 4,
   parameter int LOCK_THR     = 16,
   parameter int UNLOCK_THR   = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic                       Up,
   input  logic                       Dn,
   output logic [1:0]                 gain_sel,
   output logic                       dlf_hold,
   output logic                       cdr_locked,
   output logic                       lock_lost,
   output logic [1:0]                 state_o,
   output logic signed [WIN_LOG2+1:0] imbalance_o
);
   localparam int AW = $clog2(ACQ_WINDOWS + 1);
   localparam int GW = $clog2(LOCK_WINDOWS + 1);
   cdr_state_e state;
   logic [AW-1:0] acq_cnt, acq_nxt;
   logic [GW-1:0] good_cnt, good_nxt;
   logic win_end, good, bad, inconc;
   logic signed [WIN_LOG2+1:0] net;
   cdr_win_accum #(.WIN_LOG2(WIN_LOG2), .LOCK_THR(LOCK_THR), .UNLOCK_THR(UNLOCK_THR)) u_accum (
      .clk(clk), .rst_n(rst_n), .clear(state == IDLE), .run(state != IDLE), .up(Up), .dn(Dn),
      .win_end(win_end), .net(net), .good(good), .bad(bad), .inconc(inconc)
   );
   assign state_o = state;
   always_comb begin
      acq_nxt  = (acq_cnt == AW'(ACQ_WINDOWS)) ? acq_cnt : acq_cnt + AW'(1);
      good_nxt = good_cnt + GW'(1);
   end
   always_ff @(posedge clk) begin
      assert (LOCK_THR < UNLOCK_THR);
      if (!rst_n || !en) begin
         state       <= IDLE;
         acq_cnt     <= '0;
         good_cnt    <= '0;
         gain_sel    <= GAIN_HOLD;
         dlf_hold    <= 1'b1;
         cdr_locked  <= 1'b0;
         lock_lost   <= 1'b0;
         imbalance_o <= '0;
      end else begin
         lock_lost <= 1'b0;
         if (win_end) imbalance_o <= net;
         case (state)
            IDLE: begin
               state    <= ACQ;
               gain_sel <= GAIN_ACQ;
               dlf_hold <= 1'b0;
               acq_cnt  <= '0;
               good_cnt <= '0;
            end
            ACQ: if (win_end) begin
               acq_cnt <= acq_nxt;
               if (acq_nxt >= AW'(ACQ_WINDOWS) && good) begin
                  state    <= TRACK;
                  gain_sel <= GAIN_TRACK;
                  good_cnt <= '0;
               end
            end
            TRACK: if (win_end) begin
               if (bad) begin
                  state    <= ACQ;
                  gain_sel <= GAIN_ACQ;
                  acq_cnt  <= '0;
                  good_cnt <= '0;
               end else if (good) begin
                  good_cnt <= good_nxt;
                  if (good_nxt >= GW'(LOCK_WINDOWS)) begin
                     state      <= LOCKED;
                     cdr_locked <= 1'b1;
                  end
               end else if (!inconc) good_cnt <= '0;
            end
            LOCKED: if (win_end && bad) begin
               state      <= ACQ;
               gain_sel   <= GAIN_ACQ;
               cdr_locked <= 1'b0;
               lock_lost  <= 1'b1;
               acq_cnt    <= '0;
               good_cnt   <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// tb_cdr_lock_ctrl: table vectors, directed corner sequences and random stimulus against a window-level model
module tb_cdr_lock_ctrl;
   localparam int W = 4, WIN = 16, ACQ_W = 4, LOCK_W = 4, LTHR = 2, UTHR = 8;
   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, Up = 1'b0, Dn = 1'b0;
   logic [1:0] gain_sel, state_o;
   logic dlf_hold, cdr_locked, lock_lost;
   logic signed [W+1:0] imbalance_o;
   int n_chk = 0, n_fail = 0;
   int m_state = 0, m_acq = 0, m_good = 0, m_imb = 0;
   bit m_lost = 0, ph = 0;
   int q[$];
   typedef struct {bit r; bit e; bit u; bit d; int n; int st; int gain; int hold; int imb;} vec_t;
   vec_t tbl[6];

   cdr_lock_ctrl #(.WIN_LOG2(W), .ACQ_WINDOWS(ACQ_W), .LOCK_WINDOWS(LOCK_W), .LOCK_THR(LTHR), .UNLOCK_THR(UTHR)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .Up(Up), .Dn(Dn), .gain_sel(gain_sel), .dlf_hold(dlf_hold),
      .cdr_locked(cdr_locked), .lock_lost(lock_lost), .state_o(state_o), .imbalance_o(imbalance_o)
   );
   always #5 clk = ~clk;

   task automatic check(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model(bit r, bit e, bit u, bit d);
      int net, cnt, mag;
      bit g, b, inc;
      m_lost = 0;
      if (!r || !e) begin
         m_state = 0; q.delete(); m_imb = 0; m_acq = 0; m_good = 0;
      end else if (m_state == 0) begin
         m_state = 1; q.delete(); m_acq = 0; m_good = 0;
      end else begin
         q.push_back(u && !d ? 1 : (d && !u ? -1 : 0));
         if (q.size() == WIN) begin
            net = 0; cnt = 0;
            foreach (q[i]) begin net += q[i]; cnt += int'(q[i] != 0); end
            q.delete();
            m_imb = net;
            mag = net < 0 ? -net : net;
            inc = cnt == 0; g = !inc && mag <= LTHR; b = mag > UTHR;
            case (m_state)
               1: begin
                  if (m_acq < ACQ_W) m_acq++;
                  if (m_acq >= ACQ_W && g) begin m_state = 2; m_good = 0; end
               end
               2: if (b) begin m_state = 1; m_acq = 0; m_good = 0; end
                  else if (g) begin m_good++; if (m_good >= LOCK_W) m_state = 3; end
                  else if (!inc) m_good = 0;
               3: if (b) begin m_state = 1; m_acq = 0; m_good = 0; m_lost = 1; end
               default: ;
            endcase
         end
      end
   endtask

   task automatic cyc(bit r, bit e, bit u, bit d);
      rst_n = r; en = e; Up = u; Dn = d;
      @(posedge clk);
      model(r, e, u, d);
      #1;
      check("state_o", int'(state_o), m_state);
      check("gain_sel", int'(gain_sel), m_state == 0 ? 0 : (m_state == 1 ? 2 : 1));
      check("dlf_hold", int'(dlf_hold), int'(m_state == 0));
      check("cdr_locked", int'(cdr_locked), int'(m_state == 3));
      check("lock_lost", int'(lock_lost), int'(m_lost));
      check("imbalance_o", int'(imbalance_o), m_imb);
   endtask

   task automatic alt(int n);
      repeat (n) begin cyc(1, 1, ph, !ph); ph = !ph; end
   endtask

   task automatic to_track();
      repeat (2) cyc(0, 1, 0, 0);
      alt(65);
      check("track at cycle 65", int'(state_o), 2);
   endtask

   initial begin
      tbl = '{'{0, 1, 1, 0, 3, 0, 0, 1, 0}, '{1, 1, 1, 0, 1, 1, 2, 0, 0}, '{1, 1, 1, 0, 15, 1, 2, 0, 0},
              '{1, 1, 1, 0, 1, 1, 2, 0, 16}, '{1, 1, 1, 0, 48, 1, 2, 0, 16}, '{1, 1, 1, 0, 64, 1, 2, 0, 16}};
      foreach (tbl[i]) begin
         repeat (tbl[i].n) cyc(tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].d);
         check($sformatf("tbl%0d state", i), int'(state_o), tbl[i].st);
         check($sformatf("tbl%0d gain", i), int'(gain_sel), tbl[i].gain);
         check($sformatf("tbl%0d hold", i), int'(dlf_hold), tbl[i].hold);
         check($sformatf("tbl%0d imb", i), int'(imbalance_o), tbl[i].imb);
      end
      repeat (2) cyc(0, 1, 0, 0);
      alt(64);
      check("acq at cycle 64", int'(state_o), 1);
      alt(1);
      check("track at cycle 65", int'(state_o), 2);
      alt(63);
      check("not locked at 128", int'(cdr_locked), 0);
      alt(1);
      check("locked at 129", int'(cdr_locked), 1);
      check("imb zero alt", int'(imbalance_o), 0);
      repeat (15) cyc(1, 1, 1, 0);
      check("still locked", int'(cdr_locked), 1);
      cyc(1, 1, 1, 0);
      check("lock_lost pulse", int'(lock_lost), 1);
      check("unlocked on pulse", int'(cdr_locked), 0);
      check("acq gain on pulse", int'(gain_sel), 2);
      check("imb +16", int'(imbalance_o), 16);
      alt(1);
      check("lock_lost one cycle", int'(lock_lost), 0);
      alt(62);
      check("reacq not yet track", int'(state_o), 1);
      alt(1);
      check("retrack", int'(state_o), 2);
      alt(64);
      check("relock", int'(cdr_locked), 1);
      to_track();
      alt(32);
      repeat (16) cyc(1, 1, 1, 1);
      check("inconc stays track", int'(state_o), 2);
      repeat (5) cyc(1, 1, 1, 0);
      repeat (11) cyc(1, 1, 0, 0);
      check("neutral imb +5", int'(imbalance_o), 5);
      alt(48);
      check("good_cnt cleared", int'(state_o), 2);
      alt(16);
      check("lock after 4 good", int'(state_o), 3);
      to_track();
      alt(32);
      repeat (16) cyc(1, 1, 1, 1);
      alt(16);
      check("inconc held 3", int'(state_o), 2);
      alt(16);
      check("inconc held lock", int'(state_o), 3);
      to_track();
      repeat (2) cyc(1, 1, 1, 0);
      alt(14);
      check("good imb +2", int'(imbalance_o), 2);
      alt(5);
      cyc(1, 0, 1, 0);
      check("en drop idle", int'(state_o), 0);
      check("en drop imb", int'(imbalance_o), 0);
      check("en drop hold", int'(dlf_hold), 1);
      cyc(1, 1, 0, 0);
      alt(63);
      check("reenable acq", int'(state_o), 1);
      alt(1);
      check("reenable track", int'(state_o), 2);
      for (int w = 0; w < 150; w++) begin
         int mode = $urandom_range(0, 4);
         for (int k = 0; k < WIN; k++) begin
            bit r = $urandom_range(0, 999) != 0;
            bit e = $urandom_range(0, 299) != 0;
            bit u, d;
            case (mode)
               0: begin u = ph; d = !ph; end
               1: begin u = 1; d = 0; end
               2: begin u = 0; d = 1; end
               3: begin u = 1'($urandom); d = 1'($urandom); end
               default: if ($urandom_range(0, 7) == 0) begin u = 1; d = 0; end else begin u = ph; d = !ph; end
            endcase
            ph = !ph;
            cyc(r, e, u, d);
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
